// File: rtl/fmul_arbiter_if.sv
// Request/response bundle between two FMul requesters, the arbiter and the
// shared multiplier.
interface fmul_arbiter_if;
    logic        req0_valid;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req1_ready;
    logic [31:0] mul_in1;
    logic [31:0] mul_in2;
    logic [31:0] mul_out;
    logic [31:0] rsp_data;
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic        busy;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  mul_out,
        output req0_ready, req1_ready,
        output mul_in1, mul_in2,
        output rsp_data, rsp0_valid, rsp1_valid, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output mul_out,
        input  req0_ready, req1_ready,
        input  mul_in1, mul_in2,
        input  rsp_data, rsp0_valid, rsp1_valid, busy
    );
endinterface

// File: rtl/fmul_arbiter.sv
// Round-robin arbiter sharing one pipelined FMul between two requesters;
// a {valid,id} tag pipeline routes each product back to its owner in order.
module fmul_arbiter #(
    parameter int LAT = 3
) (
    input logic           clk,
    input logic           rst_n,
    fmul_arbiter_if.slave bus
);

    logic         ptr;
    logic         g0;
    logic         g1;
    logic         acc;
    logic [LAT:0] tv;
    logic [LAT:0] tid;

    // Readies are gated by reset so nothing is accepted while held
    always_comb begin
        g0  = rst_n & bus.req0_valid & (~bus.req1_valid | ~ptr);
        g1  = rst_n & bus.req1_valid & (~bus.req0_valid | ptr);
        acc = g0 | g1;
    end

    assign bus.req0_ready = g0;
    assign bus.req1_ready = g1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= 1'b0;
            bus.mul_in1 <= '0;
            bus.mul_in2 <= '0;
        end else if (g0) begin
            ptr         <= 1'b1;
            bus.mul_in1 <= bus.req0_a;
            bus.mul_in2 <= bus.req0_b;
        end else if (g1) begin
            ptr         <= 1'b0;
            bus.mul_in1 <= bus.req1_a;
            bus.mul_in2 <= bus.req1_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tv  <= '0;
            tid <= '0;
        end else begin
            tv  <= {tv[LAT-1:0], acc};
            tid <= {tid[LAT-1:0], g1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_data   <= '0;
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
        end else if (tv[LAT]) begin
            bus.rsp_data   <= bus.mul_out;
            bus.rsp0_valid <= ~tid[LAT];
            bus.rsp1_valid <= tid[LAT];
        end else begin
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
        end
    end

    assign bus.busy = (|tv) | bus.rsp0_valid | bus.rsp1_valid;

endmodule

// File: tb/tb_fmul_arbiter.sv
// Randomized and directed bench for fmul_arbiter against a queue-based
// model of grants, latency and in-order return.
module tb_fmul_arbiter;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fmul_arbiter_if bus();

    fmul_arbiter #(.LAT(LAT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Stand-in multiplier: exact for x2.0, arbitrary but fixed otherwise
    function automatic logic [31:0] fmul_fn(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h4000_0000) return b + 32'h0080_0000;
        return (a ^ {b[7:0], b[31:8]}) + 32'd1;
    endfunction

    logic [31:0] fp [LAT];
    always_ff @(posedge clk) begin
        fp[0] <= fmul_fn(bus.mul_in1, bus.mul_in2);
        for (int i = 1; i < LAT; i++) fp[i] <= fp[i-1];
    end
    assign bus.mul_out = fp[LAT-1];

    typedef struct {
        logic        id;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        mptr = 1'b0;
    logic [31:0] m_in1 = '0;
    logic [31:0] m_in2 = '0;
    logic [31:0] m_rsp = '0;
    logic        last_p0;
    logic        last_p1;

    task automatic step(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic v1, input logic [31:0] a1, input logic [31:0] b1);
        logic e0, e1, ev0, ev1, eb;
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
        #1;
        e0 = v0 && (!v1 || mptr == 1'b0);
        e1 = v1 && (!v0 || mptr == 1'b1);
        checks++;
        if (bus.req0_ready !== e0 || bus.req1_ready !== e1) begin
            errors++;
            $display("FAIL ready cyc=%0d got %b%b want %b%b", cyc,
                     bus.req0_ready, bus.req1_ready, e0, e1);
        end
        @(posedge clk);
        cyc++;
        if (e0) begin
            q.push_back('{1'b0, fmul_fn(a0, b0), cyc + LAT + 1});
            m_in1 = a0; m_in2 = b0; mptr = 1'b1;
        end else if (e1) begin
            q.push_back('{1'b1, fmul_fn(a1, b1), cyc + LAT + 1});
            m_in1 = a1; m_in2 = b1; mptr = 1'b0;
        end
        #1;
        ev0 = 1'b0; ev1 = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            ev0 = !q[0].id; ev1 = q[0].id; m_rsp = q[0].data;
            void'(q.pop_front());
        end
        eb = (q.size() != 0) || ev0 || ev1;
        last_p0 = bus.rsp0_valid;
        last_p1 = bus.rsp1_valid;
        checks++;
        if (bus.mul_in1 !== m_in1 || bus.mul_in2 !== m_in2) begin
            errors++;
            $display("FAIL mul_in cyc=%0d got %h/%h want %h/%h", cyc,
                     bus.mul_in1, bus.mul_in2, m_in1, m_in2);
        end
        checks++;
        if (bus.rsp0_valid !== ev0 || bus.rsp1_valid !== ev1 || bus.rsp_data !== m_rsp) begin
            errors++;
            $display("FAIL rsp cyc=%0d got %b%b %h want %b%b %h", cyc, bus.rsp0_valid,
                     bus.rsp1_valid, bus.rsp_data, ev0, ev1, m_rsp);
        end
        checks++;
        if (bus.busy !== eb) begin
            errors++;
            $display("FAIL busy cyc=%0d got %b want %b", cyc, bus.busy, eb);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || bus.busy !== 1'b0 ||
            bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0 || bus.rsp_data !== '0 ||
            bus.mul_in1 !== '0 || bus.mul_in2 !== '0) begin
            errors++;
            $display("FAIL reset_state rdy=%b%b busy=%b rsp=%b%b data=%h in=%h/%h want all 0",
                     bus.req0_ready, bus.req1_ready, bus.busy, bus.rsp0_valid,
                     bus.rsp1_valid, bus.rsp_data, bus.mul_in1, bus.mul_in2);
        end
        q.delete();
        mptr = 1'b0; m_in1 = '0; m_in2 = '0; m_rsp = '0;
        @(posedge clk);
        cyc++;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.rsp0_valid !== 1'b0 || bus.mul_in1 !== '0) begin
            errors++;
            $display("FAIL reset_hold busy=%b rsp0=%b in1=%h want 0", bus.busy,
                     bus.rsp0_valid, bus.mul_in1);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_single();
        step(1'b1, 32'h4000_0000, 32'h3FE3_D70A, 1'b0, '0, '0);
        idle(4);
        checks++;
        if (last_p0 !== 1'b1 || bus.rsp_data !== 32'h4063_D70A) begin
            errors++;
            $display("FAIL single got rsp0=%b data=%h want 1 4063d70a", last_p0, bus.rsp_data);
        end
        idle(1);
        checks++;
        if (last_p0 !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse got rsp0=%b want 0", last_p0);
        end
    endtask

    task automatic test_contention();
        logic [3:0] ids;
        int n;
        do_reset();
        for (int i = 0; i < 4; i++)
            step(1'b1, $urandom, $urandom, 1'b1, $urandom, $urandom);
        n = 0; ids = '0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, '0, '0, 1'b0, '0, '0);
            if (last_p0 || last_p1) begin
                if (n < 4) ids[n] = last_p1;
                n++;
            end
        end
        checks++;
        if (n != 4 || ids !== 4'b1010) begin
            errors++;
            $display("FAIL contention got n=%0d ids=%b want 4 1010", n, ids);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL contention_busy got %b want 0", bus.busy);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b1, $urandom, $urandom);
        idle(LAT + 2);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL stream_ptr got rdy=%b%b want 10", bus.req0_ready, bus.req1_ready);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic test_idle();
        step(1'b1, $urandom, $urandom, 1'b0, '0, '0);
        idle(5);
        idle(5);
        checks++;
        if (bus.busy !== 1'b0 || bus.mul_in1 !== m_in1) begin
            errors++;
            $display("FAIL idle got busy=%b in1=%h want 0 %h", bus.busy, bus.mul_in1, m_in1);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        step(1'b1, $urandom, $urandom, 1'b0, '0, '0);
        step(1'b0, '0, '0, 1'b1, $urandom, $urandom);
        idle(2);
        do_reset();
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, '0, 1'b0, '0, '0);
            pulses += int'(last_p0) + int'(last_p1);
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_mid got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_alternating();
        int starved;
        starved = 0;
        for (int i = 0; i < 10; i++) begin
            bus.req0_valid = 1'b1;
            bus.req1_valid = i[0];
            #1;
            if (i[0] && bus.req1_ready !== 1'b1) starved++;
            step(1'b1, $urandom, $urandom, i[0], $urandom, $urandom);
        end
        checks++;
        if (starved != 0) begin
            errors++;
            $display("FAIL alternating got %0d starved req1 want 0", starved);
        end
        idle(LAT + 2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), $urandom, $urandom,
                 1'($urandom_range(0, 1)), $urandom, $urandom);
        idle(LAT + 3);
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        last_p0 = 1'b0; last_p1 = 1'b0;
        #2;
        test_reset();
        test_single();
        test_contention();
        test_stream();
        test_idle();
        test_reset_mid();
        test_alternating();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fmul_arbiter.md
FMUL_ARBITER -- requirements
Module: fmul_arbiter

Interface
REQ-001 SHALL have parameter LAT, default 3, the shared FMul pipeline depth: cycles from operands presented on mul_in1/mul_in2 to the matching product on mul_out.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req0_valid  input  1  requester 0 has an operand pair.
REQ-005 SHALL have port req0_a, req0_b  input  32 each  requester 0 IEEE-754 single operands.
REQ-006 SHALL have port req0_ready  output  1  requester 0 pair accepted this cycle.
REQ-007 SHALL have port req1_valid, req1_a, req1_b, req1_ready, identical to REQ-004..006, for requester 1.
REQ-008 SHALL have port mul_in1, mul_in2  output  32 each  registered operands driven to the shared FMul.
REQ-009 SHALL have port mul_out  input  32  product from the shared FMul.
REQ-010 SHALL have port rsp_data  output  32  registered product, shared by both requesters.
REQ-011 SHALL have port rsp0_valid, rsp1_valid  output  1 each  one-cycle pulse; rsp_data belongs to that requester.
REQ-012 SHALL have port busy  output  1  high while any accepted operation has not yet been returned.

Function
REQ-013 Accept: a pair is accepted at a rising edge when reqN_valid and reqN_ready are both high; reqN_ready SHALL be combinational from the valids and the priority pointer only.
REQ-014 At most one requester SHALL be granted per cycle; an idle shared multiplier SHALL grant a single valid requester in the same cycle (no bubble).
REQ-015 Round-robin: pointer ptr holds the preferred requester; when both requesters are valid, ptr wins; after any grant, ptr <= the requester not granted; with no grant, ptr SHALL hold.
REQ-016 On accept, mul_in1 <= reqN_a and mul_in2 <= reqN_b at that edge; with no accept, mul_in1/mul_in2 SHALL hold their previous values.
REQ-017 Tag pipeline: LAT+1 stages of {valid, id}; stage 0 <= {accept, granted id} every edge; stage i <= stage i-1.
REQ-018 When the last stage is valid, rsp_data <= mul_out and rsp{id}_valid <= 1 at the next edge; otherwise both rsp valids <= 0 and rsp_data SHALL hold.
REQ-019 Latency: rsp pulse SHALL be high in the cycle after the (LAT+1)-th edge following the accept edge; with LAT=3, four cycles after acceptance.
REQ-020 Throughput: one accept per cycle sustained; no backpressure on responses; results SHALL return strictly in acceptance order.
REQ-021 rsp0_valid and rsp1_valid SHALL never be high in the same cycle.
REQ-022 busy SHALL be the OR of all tag stage valids and any rsp valid.
REQ-023 Operand values SHALL pass through unmodified; the block does no arithmetic, rounding or exception handling.

Reset
REQ-024 rst_n low SHALL immediately clear: all tag stages invalid, rsp0_valid=0, rsp1_valid=0, rsp_data=0, mul_in1=0, mul_in2=0, ptr=0 (requester 0 preferred).
REQ-025 While rst_n is low, req0_ready and req1_ready SHALL be 0.
REQ-026 Operations in flight at reset SHALL be discarded; no response pulse SHALL be produced for them after release.
REQ-027 The first rising edge with rst_n high SHALL accept normally.

Verification
REQ-028 Single op, LAT=3: req0 a=0x40000000, b=0x3FE3D70A accepted at edge 0 -> mul_in1/mul_in2 show them after edge 0; rsp0_valid=1 with rsp_data=0x4063D70A after edge 4, one cycle only.
REQ-029 Contention: both valid for 4 cycles from reset -> grants 0,1,0,1; rsp0,rsp1,rsp0,rsp1 pulses on 4 consecutive cycles; busy falls after the last pulse.
REQ-030 Streaming: req1 alone valid for 6 cycles -> req1_ready high all 6; 6 consecutive rsp1_valid pulses in order; ptr ends at 0.
REQ-031 Idle hold: no valids for 5 cycles after an op -> mul_in1/mul_in2 unchanged; rsp valids 0; busy 0 once the response has returned.
REQ-032 Reset mid-flight: 2 ops accepted, rst_n low 1 cycle before their return -> all outputs 0 immediately; no rsp pulse for 10 cycles after release.
REQ-033 Alternating priority: req0 valid every cycle, req1 valid every other cycle -> req1 is never starved; each req1 request is granted in the cycle it is raised.
